// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-bridge state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by the
// read and write bridges.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_i;
        incr_addr = addr_i + step;
        // Wrap window is the whole burst length in bytes; the low bits roll over.
        wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_addr;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_axil_rd_burst_bridge.sv
// AXI4 read burst to AXI-Lite single-beat read bridge with a bounded number of
// lite reads in flight; illegal bursts are answered locally with SLVERR beats.
module axi_axil_rd_burst_bridge
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int              OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]   MAX_OUT  = OW'(MAX_OUTSTANDING);
    localparam logic [2:0]      SIZE_MAX = 3'($clog2(DATA_WIDTH / 8));

    state_t                state_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [2:0]            arprot_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic [8:0]            issue_cnt_q;
    logic [8:0]            ret_cnt_q;
    logic [OW-1:0]         outst_q;

    logic                  ar_hs;
    logic                  lite_ar_hs;
    logic                  lite_r_hs;
    logic                  err_r_hs;
    logic                  burst_bad;
    logic [8:0]            issue_cnt_d;
    logic [OW-1:0]         outst_d;
    logic [ADDR_WIDTH-1:0] next_addr;

    wire unused_ok = &{1'b0, s_axi_arlock, s_axi_arcache};

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i      (araddr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    assign s_axi_arready  = (state_q == IDLE);
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = arprot_q;
    assign m_axil_arvalid = arvalid_q;

    // Return path is a straight pass-through in RUN; ERR fabricates SLVERR beats.
    always_comb begin
        s_axi_rvalid  = 1'b0;
        s_axi_rdata   = '0;
        s_axi_rresp   = RESP_OKAY;
        m_axil_rready = 1'b0;
        case (state_q)
            RUN: begin
                s_axi_rvalid  = m_axil_rvalid;
                s_axi_rdata   = m_axil_rdata;
                s_axi_rresp   = m_axil_rresp;
                m_axil_rready = s_axi_rready;
            end
            ERR: begin
                s_axi_rvalid  = 1'b1;
                s_axi_rresp   = RESP_SLVERR;
            end
            default: ;
        endcase
    end

    assign s_axi_rid   = id_q;
    assign s_axi_rlast = (state_q != IDLE) && (ret_cnt_q == 9'd1);

    assign ar_hs      = s_axi_arvalid && (state_q == IDLE);
    assign lite_ar_hs = arvalid_q && m_axil_arready;
    assign lite_r_hs  = (state_q == RUN) && m_axil_rvalid && s_axi_rready;
    assign err_r_hs   = (state_q == ERR) && s_axi_rready;

    assign burst_bad = (s_axi_arsize > SIZE_MAX) ||
                       (s_axi_arburst == 2'b11) ||
                       ((s_axi_arburst == BURST_WRAP) && !wrap_len_ok(s_axi_arlen));

    assign issue_cnt_d = issue_cnt_q - {8'd0, lite_ar_hs};
    assign outst_d     = outst_q + OW'(lite_ar_hs) - OW'(lite_r_hs);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            id_q        <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            arprot_q    <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            outst_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        id_q        <= s_axi_arid;
                        len_q       <= s_axi_arlen;
                        size_q      <= s_axi_arsize;
                        burst_q     <= s_axi_arburst;
                        arprot_q    <= s_axi_arprot;
                        araddr_q    <= s_axi_araddr;
                        issue_cnt_q <= {1'b0, s_axi_arlen} + 9'd1;
                        ret_cnt_q   <= {1'b0, s_axi_arlen} + 9'd1;
                        outst_q     <= '0;
                        if (burst_bad) begin
                            state_q   <= ERR;
                            arvalid_q <= 1'b0;
                        end else begin
                            state_q   <= RUN;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    issue_cnt_q <= issue_cnt_d;
                    outst_q     <= outst_d;
                    if (lite_ar_hs) begin
                        araddr_q <= next_addr;
                    end
                    if (lite_r_hs) begin
                        ret_cnt_q <= ret_cnt_q - 9'd1;
                    end
                    if (lite_r_hs && (ret_cnt_q == 9'd1)) begin
                        state_q   <= IDLE;
                        arvalid_q <= 1'b0;
                    end else begin
                        arvalid_q <= (issue_cnt_d != 9'd0) && (outst_d < MAX_OUT);
                    end
                end
                ERR: begin
                    if (err_r_hs) begin
                        ret_cnt_q <= ret_cnt_q - 9'd1;
                        if (ret_cnt_q == 9'd1) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_axil_rd_burst_bridge.sv
// Randomised bench for the AXI4-to-AXI-Lite read bridge with a lite slave model
// and a burst-level reference model.
module tb_axi_axil_rd_burst_bridge;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic [7:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arlock = 1'b0;
    logic [3:0]  s_axi_arcache = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready = 1'b1;
    logic [31:0] m_axil_rdata = '0;
    logic [1:0]  m_axil_rresp = '0;
    logic        m_axil_rvalid = 1'b0;
    logic        m_axil_rready;

    axi_axil_rd_burst_bridge #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .ID_WIDTH        (8),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_axi_arid     (s_axi_arid),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arlen    (s_axi_arlen),
        .s_axi_arsize   (s_axi_arsize),
        .s_axi_arburst  (s_axi_arburst),
        .s_axi_arprot   (s_axi_arprot),
        .s_axi_arlock   (s_axi_arlock),
        .s_axi_arcache  (s_axi_arcache),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_rid      (s_axi_rid),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rresp    (s_axi_rresp),
        .s_axi_rlast    (s_axi_rlast),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          due;
    } lite_rsp_t;

    lite_rsp_t   pend[$];
    logic [31:0] obs_addr[$];
    logic [63:0] obs_r[$];

    int cyc = 0;
    int outst = 0;
    int outst_max = 0;
    int lite_idx = 0;
    int cfg_lat = 1;
    int cfg_err = 1000;
    bit ar_stall = 1'b0;
    bit r_stall = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkdata(input logic [31:0] a, input int k);
        return {a[15:0], 8'h5A, 8'(k)};
    endfunction

    // Observe handshakes with pre-edge values.
    always @(posedge clk) begin
        if (rstn) begin
            if (m_axil_arvalid && m_axil_arready) begin
                obs_addr.push_back(m_axil_araddr);
                pend.push_back('{data: mkdata(m_axil_araddr, lite_idx),
                                 resp: (lite_idx == cfg_err) ? 2'b10 : 2'b00,
                                 due:  cyc + cfg_lat});
                lite_idx++;
                outst++;
            end
            if (m_axil_rvalid && m_axil_rready) begin
                void'(pend.pop_front());
                outst--;
            end
            if (outst > outst_max) outst_max = outst;
            if (s_axi_rvalid && s_axi_rready)
                obs_r.push_back({21'd0, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast});
        end
        cyc++;
    end

    // Lite slave and random backpressure, driven away from the active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            m_axil_rvalid = 1'b0;
            m_axil_rdata  = '0;
            m_axil_rresp  = '0;
        end else begin
            m_axil_arready = ar_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axi_rready   = r_stall  ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pend.size() > 0 && cyc >= pend[0].due) begin
                m_axil_rvalid = 1'b1;
                m_axil_rdata  = pend[0].data;
                m_axil_rresp  = pend[0].resp;
            end else begin
                m_axil_rvalid = 1'b0;
                m_axil_rdata  = '0;
                m_axil_rresp  = '0;
            end
        end
    end

    task automatic start_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int tmo = 0;
        @(negedge clk);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arprot  = id[2:0];
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        chk("ar_accept", s_axi_arready, 1);
        @(posedge clk);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_rresp,
                  m_axil_arvalid, m_axil_araddr, m_axil_arprot, m_axil_rready},
            {1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0});
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int lat,
                             input int err_idx, input bit ars, input bit rs);
        int unsigned bytes, total, base, a;
        int n, t0, w;
        bit legal;
        logic [63:0] exp;
        n     = int'(len) + 1;
        bytes = 32'd1 << size;
        legal = (size <= 3'd2) && (burst != 2'b11) &&
                !(burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        obs_addr.delete();
        obs_r.delete();
        lite_idx  = 0;
        outst_max = 0;
        cfg_lat   = lat;
        cfg_err   = err_idx;
        ar_stall  = ars;
        r_stall   = rs;

        start_ar(id, addr, len, size, burst);
        t0 = cyc;
        chk("arready_fall", s_axi_arready, 0);
        if (legal) begin
            chk("first_lite_arvalid", m_axil_arvalid, 1);
            chk("lite_arprot", m_axil_arprot, id[2:0]);
        end else begin
            chk("err_first_rvalid", s_axi_rvalid, 1);
            chk("err_no_lite_arvalid", m_axil_arvalid, 0);
        end

        w = 0;
        while (obs_r.size() < n && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk("beat_count", obs_r.size(), n);
        if (obs_r.size() == n) chk("arready_back", s_axi_arready, 1);
        if (!ars && !rs && (!legal || lat == 1))
            chk("burst_cycles", cyc - t0, legal ? n + 1 : n);
        chk("lite_count", obs_addr.size(), legal ? n : 0);
        chk("outst_limit", outst_max > MAXO, 0);

        total = bytes * n;
        base  = (total != 0) ? (addr / total) * total : addr;
        for (int k = 0; k < n; k++) begin
            if (burst == 2'b00)      a = addr;
            else if (burst == 2'b01) a = addr + k * bytes;
            else                     a = base + ((addr - base) + k * bytes) % total;
            if (legal && k < obs_addr.size())
                chk($sformatf("lite_addr[%0d]", k), obs_addr[k], a);
            if (legal)
                exp = {21'd0, id, mkdata(a, k), (k == err_idx) ? 2'b10 : 2'b00, k == n - 1};
            else
                exp = {21'd0, id, 32'h0, 2'b10, k == n - 1};
            if (k < obs_r.size())
                chk($sformatf("beat[%0d]", k), obs_r[k], exp);
        end
        ar_stall = 1'b0;
        r_stall  = 1'b0;
    endtask

    initial begin
        int wl[4] = '{1, 3, 7, 15};
        int unsigned sel;
        logic [1:0]  bt;
        logic [2:0]  sz;
        logic [7:0]  ln;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rstn = 1'b1;

        run_burst(8'h3C, 32'h100, 8'd3, 3'd2, 2'b01, 1, 1000, 0, 0);
        run_burst(8'h51, 32'h10C, 8'd3, 3'd2, 2'b10, 1, 1000, 0, 0);
        run_burst(8'h07, 32'h40,  8'd2, 3'd2, 2'b00, 1, 2,    0, 0);
        run_burst(8'hA2, 32'h2000, 8'd7, 3'd2, 2'b01, 5, 1000, 0, 0);
        run_burst(8'h99, 32'h200, 8'd1, 3'd3, 2'b01, 1, 1000, 0, 0);
        run_burst(8'h5E, 32'h300, 8'd1, 3'd2, 2'b11, 1, 1000, 0, 0);
        run_burst(8'h12, 32'h400, 8'd0, 3'd0, 2'b01, 1, 0,    0, 0);

        // Reset in the middle of a long burst, then a clean burst afterwards.
        cfg_lat = 5;
        start_ar(8'hEE, 32'h800, 8'd15, 3'd2, 2'b01);
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_burst_reset");
        pend.delete();
        outst = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_burst(8'h6B, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01, 2, 1, 1, 1);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            bt  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            sz  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (bt == 2'b10)
                ln = ($urandom_range(0, 7) == 0) ? 8'd2 : 8'(wl[$urandom_range(0, 3)]);
            else
                ln = 8'($urandom_range(0, 15));
            run_burst(8'($urandom), $urandom, ln, sz, bt, $urandom_range(1, 5),
                      $urandom_range(0, int'(ln) + 4), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_axil_rd_burst_bridge.md
# axi_axil_rd_burst_bridge

Read-side AXI4 to AXI4-Lite bridge that splits AXI4 read bursts of any legal type (FIXED, INCR, WRAP) into single-beat AXI-Lite reads. Up to MAX_OUTSTANDING lite reads are kept in flight per burst, so a pipelined lite slave can return one beat per cycle. Illegal bursts are answered with SLVERR beats and generate no lite traffic. The block sits between an AXI4 interconnect master port and AXI-Lite register/memory slaves.

## Interface
- ADDR_WIDTH, 32: address width, both sides.
- DATA_WIDTH, 32: data width, both sides. Must be 8·2^n.
- ID_WIDTH, 8: AXI ID width.
- MAX_OUTSTANDING, 4: maximum lite ARs issued but not yet returned. Must be ≥1.
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_axi_arid/araddr/arlen/arsize/arburst/arprot  in  ID_WIDTH/ADDR_WIDTH/8/3/2/3  AXI4 read address fields.
- s_axi_arlock/arcache  in  1/4  accepted and ignored.
- s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  AXI4 read data.
- s_axi_rvalid  out  1;  s_axi_rready  in  1.
- m_axil_araddr/arprot  out  ADDR_WIDTH/3;  m_axil_arvalid  out  1;  m_axil_arready  in  1.
- m_axil_rdata/rresp  in  DATA_WIDTH/2;  m_axil_rvalid  in  1;  m_axil_rready  out  1.

## Operation
- States: IDLE, RUN, ERR. One burst is handled at a time.
- IDLE: s_axi_arready=1. On AR handshake, capture id, addr, len, size, burst and prot. Load issue_cnt=len+1 and ret_cnt=len+1.
  - Go to ERR if arsize > log2(DATA_WIDTH/8), arburst==2'b11, or (WRAP and arlen ∉ {1,3,7,15}).
  - Otherwise go to RUN.
- RUN, issue side:
  - m_axil_arvalid=1 while issue_cnt>0 and outstanding<MAX_OUTSTANDING.
  - m_axil_araddr and arprot are registered and held stable while arvalid=1 and arready=0.
  - On lite AR handshake: issue_cnt−1, address advances.
- RUN, return side:
  - s_axi_rvalid=m_axil_rvalid and m_axil_rready=s_axi_rready (combinational pass-through).
  - rdata and rresp pass through; rid=captured id; rlast=(ret_cnt==1).
  - On handshake: ret_cnt−1. On last beat: go to IDLE.
- outstanding counter:
  - +1 on a lite AR handshake, −1 on an R handshake, unchanged when both occur in the same cycle.
  - Width clog2(MAX_OUTSTANDING+1).
- ERR: no lite traffic. s_axi_rvalid=1, rresp=2'b10 (SLVERR), rdata=0, rid=captured id. Emits len+1 beats, rlast on the final beat, then goes to IDLE.
- Address arithmetic, all modulo 2^ADDR_WIDTH:
  - FIXED: address unchanged.
  - INCR: addr + (1<<size).
  - WRAP: mask = ((len+1)<<size)−1; next = (addr & ~mask) | ((addr+(1<<size)) & mask).
  - Unaligned start addresses are passed through unmodified. 4 KB crossings are not checked.
- Lite rresp values are passed through per beat; an error beat does not abort the burst.

## Timing
- Reset values: s_axi_arready=1 (state IDLE), s_axi_rvalid=0, s_axi_rlast=0, s_axi_rid=0, s_axi_rresp=0, m_axil_arvalid=0, m_axil_araddr=0, m_axil_arprot=0, m_axil_rready=0.
- Reset asserted mid-burst: all state clears immediately and lite reads in flight are abandoned. The lite slave must be reset on the same rstn.
- s_axi_arready falls the cycle after the AR handshake. First m_axil_arvalid appears 1 cycle after the AR handshake.
- Throughput: with a zero-latency-backpressure lite slave and MAX_OUTSTANDING ≥ lite read latency+1, one beat is issued and one returned per cycle.
- s_axi_arready returns to 1 the cycle after the final R handshake. The minimum gap from the last beat to the next AR accept is 1 cycle.
- ERR beats: the first s_axi_rvalid appears 1 cycle after the AR handshake.

## Structure
- Shared package axi_pkg:
  - Burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
  - Response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - State enum {IDLE, RUN, ERR}.
- Sub-module axi_burst_addr_gen: combinational next-address from (addr, len, size, burst), parametrised by ADDR_WIDTH. It is reused by the future write-side bridge.

## Test plan
- INCR, araddr=0x100, arlen=3, arsize=2, lite latency 1 → lite addrs 0x100, 0x104, 0x108, 0x10C; 4 R beats with rid echoed and rlast only on beat 4.
- WRAP, araddr=0x10C, arlen=3, arsize=2 → lite addrs 0x10C, 0x100, 0x104, 0x108.
- FIXED, araddr=0x40, arlen=2 → three lite reads at 0x40; third lite rresp=SLVERR is passed through on beat 3.
- MAX_OUTSTANDING=2, lite slave delays R by 5 cycles, arlen=7 → outstanding never exceeds 2; all 8 beats arrive in order.
- Illegal bursts: arsize=3 on DATA_WIDTH=32, arlen=1 → 2 SLVERR beats, rdata=0, m_axil_arvalid stays 0. arburst=2'b11 gives the same result.
- Random s_axi_rready and m_axil_arready stalls; rstn pulsed mid-burst → all outputs return to reset values, and the next burst completes correctly.
